// File: rtl/ice40_io_pkg.sv
// Shared pin-mode encodings for the behavioural iCE40 I/O cell model.
// PIN_TYPE[5:2] selects the output mode, PIN_TYPE[1:0] the input mode.
package ice40_io_pkg;

    typedef enum logic [3:0] {
        OUT_DDR        = 4'b0100,
        OUT_REG        = 4'b0101,
        OUT_SIMPLE     = 4'b0110,
        OUT_TRI        = 4'b1010,
        OUT_REG_OE_REG = 4'b1101
    } out_mode_e;

    typedef enum logic [1:0] {
        IN_REG    = 2'b00,
        IN_SIMPLE = 2'b01
    } in_mode_e;

    localparam logic [5:0] PIN_BUS    = 6'b101001;
    localparam logic [5:0] PIN_VIDEO  = 6'b010100;
    localparam logic [5:0] PIN_DDRCLK = 6'b010000;

    function automatic bit pin_type_ok(input logic [5:0] t);
        return (t[5:2] inside {OUT_SIMPLE, OUT_REG, OUT_DDR, OUT_TRI, OUT_REG_OE_REG}) &&
               (t[1:0] inside {IN_SIMPLE, IN_REG});
    endfunction

endpackage

// File: rtl/ice40_io_bit.sv
// One pin slice of the I/O cell: output/OE registers, DDR mux, input samplers.
module ice40_io_bit
    import ice40_io_pkg::*;
#(
    parameter out_mode_e OUT_MODE = OUT_TRI,
    parameter in_mode_e  IN_MODE  = IN_SIMPLE,
    parameter bit        PULLUP   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_en,
    input  logic out_ena,
    input  logic d_out_0,
    input  logic d_out_1,
    output logic d_in_0,
    output logic d_in_1,
    inout  logic pin
);

    logic q0;
    logic q1;
    logic oe_q;
    logic in_q0;
    logic in_q1;
    logic oe;
    logic dout;
    logic pin_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q0    <= 1'b0;
            oe_q  <= 1'b0;
            in_q0 <= 1'b0;
        end else if (clk_en) begin
            q0    <= d_out_0;
            oe_q  <= out_ena;
            in_q0 <= pin_val;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset_n) begin
            q1    <= 1'b0;
            in_q1 <= 1'b0;
        end else if (clk_en) begin
            q1    <= d_out_1;
            in_q1 <= pin_val;
        end
    end

    always_comb begin
        oe   = 1'b0;
        dout = 1'b0;
        case (OUT_MODE)
            OUT_SIMPLE:     begin oe = 1'b1;    dout = d_out_0;          end
            OUT_REG:        begin oe = 1'b1;    dout = q0;               end
            OUT_DDR:        begin oe = 1'b1;    dout = clk ? q0 : q1;    end
            OUT_TRI:        begin oe = out_ena; dout = d_out_0;          end
            OUT_REG_OE_REG: begin oe = oe_q;    dout = q0;               end
            default:        begin oe = 1'b0;    dout = 1'b0;             end
        endcase
    end

    assign pin = oe ? dout : 1'bz;

    // Own drive wins when enabled, so the input path never sees contention.
    assign pin_val = oe ? dout : pin;

    if (PULLUP) begin : g_pullup
        pullup (pin);
    end

    assign d_in_0 = (IN_MODE == IN_SIMPLE) ? pin_val : in_q0;
    assign d_in_1 = in_q1;

endmodule

// File: rtl/ice40_io_cell.sv
// WIDTH-bit behavioural SB_IO replacement; slices share clock, reset, enables.
module ice40_io_cell
    import ice40_io_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter logic [5:0]  PIN_TYPE = 6'b101001,
    parameter bit          PULLUP   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             clk_en_i,
    input  logic             out_ena_i,
    input  logic [WIDTH-1:0] d_out_0_i,
    input  logic [WIDTH-1:0] d_out_1_i,
    output logic [WIDTH-1:0] d_in_0_o,
    output logic [WIDTH-1:0] d_in_1_o,
    inout  logic [WIDTH-1:0] pin_io
);

    if (!pin_type_ok(PIN_TYPE)) begin : g_bad_pin_type
        $fatal(1, "ice40_io_cell: unsupported PIN_TYPE 6'b%06b", PIN_TYPE);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        ice40_io_bit #(
            .OUT_MODE (out_mode_e'(PIN_TYPE[5:2])),
            .IN_MODE  (in_mode_e'(PIN_TYPE[1:0])),
            .PULLUP   (PULLUP)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n_i),
            .clk_en  (clk_en_i),
            .out_ena (out_ena_i),
            .d_out_0 (d_out_0_i[i]),
            .d_out_1 (d_out_1_i[i]),
            .d_in_0  (d_in_0_o[i]),
            .d_in_1  (d_in_1_o[i]),
            .pin     (pin_io[i])
        );
    end

endmodule

// File: tb/tb_ice40_io_cell.sv
// Bench for ice40_io_cell: bus, video, DDR clock, registered-OE and pull-up variants.
module tb_ice40_io_cell;
    import ice40_io_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_en;
    logic       out_ena;
    logic [7:0] d_out_0;
    logic [7:0] d_out_1;

    logic       ext_en_bus = 1'b0;
    logic [7:0] ext_bus    = '0;
    logic       ext_en_roe = 1'b0;
    logic [7:0] ext_roe    = '0;

    wire  [7:0] pin_bus;
    wire  [7:0] pin_vid;
    wire  [0:0] pin_ddr;
    wire  [7:0] pin_roe;
    wire  [7:0] pin_pu;

    logic [7:0] din0_bus, din1_bus, din0_vid, din1_vid, din0_roe, din1_roe, din0_pu, din1_pu;
    logic [0:0] din0_ddr, din1_ddr;

    int total = 0;
    int bad   = 0;

    assign pin_bus = ext_en_bus ? ext_bus : 'z;
    assign pin_roe = ext_en_roe ? ext_roe : 'z;

    always #5 clk = ~clk;

    ice40_io_cell #(.WIDTH(8), .PIN_TYPE(PIN_BUS), .PULLUP(1'b0)) u_bus (
        .clk(clk), .reset_n_i(reset_n), .clk_en_i(clk_en), .out_ena_i(out_ena),
        .d_out_0_i(d_out_0), .d_out_1_i(d_out_1), .d_in_0_o(din0_bus), .d_in_1_o(din1_bus),
        .pin_io(pin_bus));

    ice40_io_cell #(.WIDTH(8), .PIN_TYPE(PIN_VIDEO), .PULLUP(1'b0)) u_vid (
        .clk(clk), .reset_n_i(reset_n), .clk_en_i(clk_en), .out_ena_i(out_ena),
        .d_out_0_i(d_out_0), .d_out_1_i(d_out_1), .d_in_0_o(din0_vid), .d_in_1_o(din1_vid),
        .pin_io(pin_vid));

    ice40_io_cell #(.WIDTH(1), .PIN_TYPE(PIN_DDRCLK), .PULLUP(1'b0)) u_ddr (
        .clk(clk), .reset_n_i(reset_n), .clk_en_i(clk_en), .out_ena_i(out_ena),
        .d_out_0_i(d_out_0[0:0]), .d_out_1_i(d_out_1[0:0]), .d_in_0_o(din0_ddr),
        .d_in_1_o(din1_ddr), .pin_io(pin_ddr));

    ice40_io_cell #(.WIDTH(8), .PIN_TYPE(6'b110100), .PULLUP(1'b0)) u_roe (
        .clk(clk), .reset_n_i(reset_n), .clk_en_i(clk_en), .out_ena_i(out_ena),
        .d_out_0_i(d_out_0), .d_out_1_i(d_out_1), .d_in_0_o(din0_roe), .d_in_1_o(din1_roe),
        .pin_io(pin_roe));

    ice40_io_cell #(.WIDTH(8), .PIN_TYPE(PIN_BUS), .PULLUP(1'b1)) u_pu (
        .clk(clk), .reset_n_i(reset_n), .clk_en_i(clk_en), .out_ena_i(out_ena),
        .d_out_0_i(d_out_0), .d_out_1_i(d_out_1), .d_in_0_o(din0_pu), .d_in_1_o(din1_pu),
        .pin_io(pin_pu));

    typedef struct {
        logic       oe;
        logic [7:0] d0;
        logic       ext_en;
        logic [7:0] ext;
        logic [7:0] exp_pin;
        logic [7:0] exp_pu;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bus_exp, vid_exp, vid_din0_exp, vid_din1_exp, bus_din1_exp;
        logic       oe, ce;
        logic [7:0] d0, ext;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 8'hA5, 1'b1, 8'h3C, 8'h3C, 8'hFF};
        vecs[2] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 8'hFF};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vecs[5] = '{1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF};

        // Reset: registered outputs forced low, combinational path still live.
        reset_n = 1'b0; clk_en = 1'b1; out_ena = 1'b1; d_out_0 = 8'hFF; d_out_1 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_vid_pin", pin_vid, 8'h00);
            check("rst_bus_comb", pin_bus, 8'hFF);
        end

        // Release: first capture on the first rising edge with reset_n high.
        reset_n = 1'b1; d_out_0 = 8'h00;
        tick();
        check("vid_after_rel", pin_vid, 8'h00);
        d_out_0 = 8'hFF; #1;
        check("vid_lat_before_edge", pin_vid, 8'h00);
        tick();
        check("vid_step_1", pin_vid, 8'hFF);
        d_out_0 = 8'h00;
        tick();
        check("vid_step_0", pin_vid, 8'h00);

        // Combinational bus and pull-up vectors.
        for (int i = 0; i < 6; i++) begin
            out_ena = vecs[i].oe; d_out_0 = vecs[i].d0;
            ext_en_bus = vecs[i].ext_en; ext_bus = vecs[i].ext;
            #1;
            check($sformatf("bus_pin[%0d]", i), pin_bus, vecs[i].exp_pin);
            check($sformatf("bus_din0[%0d]", i), din0_bus, vecs[i].exp_pin);
            check($sformatf("pu_din0[%0d]", i), din0_pu, vecs[i].exp_pu);
        end
        ext_en_bus = 1'b0; out_ena = 1'b0;

        // Clock-enable hold, then reset overriding a dropped clock enable.
        tick();
        d_out_0 = 8'hFF;
        tick();
        check("ce_load", pin_vid, 8'hFF);
        clk_en = 1'b0; d_out_0 = 8'h00;
        tick(); tick();
        check("ce_hold", pin_vid, 8'hFF);
        clk_en = 1'b1;
        tick();
        check("ce_resume", pin_vid, 8'h00);
        d_out_0 = 8'hFF;
        tick();
        clk_en = 1'b0; reset_n = 1'b0;
        tick();
        check("rst_over_ce", pin_vid, 8'h00);
        reset_n = 1'b1; clk_en = 1'b1;

        // DDR clock: D0=0, D1=1 so pin tracks ~clk.
        d_out_0 = 8'h00; d_out_1 = 8'hFF;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            check("ddr_hi", 8'(pin_ddr), 8'h00);
            @(negedge clk); #2;
            check("ddr_lo", 8'(pin_ddr), 8'h01);
        end

        // Registered data + registered OE with registered input.
        out_ena = 1'b0;
        tick();
        d_out_0 = 8'h96; out_ena = 1'b1;
        tick();
        check("roe_drive", pin_roe, 8'h96);
        tick();
        check("roe_din_lag", din0_roe, 8'h96);
        out_ena = 1'b0; #1;
        check("roe_hold", pin_roe, 8'h96);
        tick();
        ext_en_roe = 1'b1; ext_roe = 8'h5A; #1;
        check("roe_released", pin_roe, 8'h5A);
        check("roe_din_old", din0_roe, 8'h96);
        tick();
        check("roe_din_new", din0_roe, 8'h5A);
        ext_en_roe = 1'b0;

        // Random traffic against a high-level model.
        d_out_0 = 8'hC3; clk_en = 1'b1;
        tick(); tick();
        vid_exp = 8'hC3; vid_din0_exp = 8'hC3; vid_din1_exp = 8'hC3; bus_din1_exp = 8'h00;
        for (int n = 0; n < 200; n++) begin
            oe  = 1'($urandom);
            d0  = 8'($urandom);
            ext = 8'($urandom);
            ce  = (n == 0) ? 1'b1 : (($urandom % 4) != 0);
            out_ena = oe; d_out_0 = d0; d_out_1 = 8'($urandom); clk_en = ce;
            ext_en_bus = !oe; ext_bus = ext;
            #1;
            bus_exp = oe ? d0 : ext;
            check("rnd_bus_pin", pin_bus, bus_exp);
            check("rnd_bus_din0", din0_bus, bus_exp);
            check("rnd_pu_pin", pin_pu, oe ? d0 : 8'hFF);
            @(negedge clk); #1;
            if (ce) begin
                bus_din1_exp = bus_exp;
                vid_din1_exp = vid_exp;
            end
            check("rnd_bus_din1", din1_bus, bus_din1_exp);
            check("rnd_vid_din1", din1_vid, vid_din1_exp);
            @(posedge clk); #1;
            if (ce) begin
                vid_din0_exp = vid_exp;
                vid_exp = d0;
            end
            check("rnd_vid_pin", pin_vid, vid_exp);
            check("rnd_vid_din0", din0_vid, vid_din0_exp);
        end
        ext_en_bus = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
